mac_accumulator: RTL and testbench

MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

---
 rtl/mac_accumulator_pkg.sv | 14 +
 rtl/mac_accumulator_valid.sv | 33 +++
 rtl/mac_accumulator.sv | 97 +++++++++
 tb/tb_mac_accumulator.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mac_accumulator_pkg.sv
// Shared defaults and FSM state type for the multiply-accumulate frame summer.
package mac_accumulator_pkg;

  localparam int DEF_PROD_W = 64;
  localparam int DEF_ACC_W  = 72;
  localparam int DEF_LAT    = 2;
  localparam int DEF_LEN_W  = 8;

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

endpackage

// File: rtl/mac_accumulator_valid.sv
// Issue-strobe delay line matching the multiplier pipeline depth.
module valid_delay #(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic pending
);

  logic [LAT-1:0] sr;

  generate
    for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) sr[gi] <= 1'b0;
          else        sr[gi] <= din;
        end
      end else begin : g_tail
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) sr[gi] <= 1'b0;
          else        sr[gi] <= sr[gi-1];
        end
      end
    end
  endgenerate

  assign dout    = sr[LAT-1];
  assign pending = |sr;

endmodule

// File: rtl/mac_accumulator.sv
// Sums signed multiplier products into frames of a latched length and
// presents each frame sum through a one-entry valid/ready output register.
module mac_accumulator
  import mac_accumulator_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int LAT    = DEF_LAT,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [LEN_W-1:0]  len,
  input  logic [PROD_W-1:0] product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              busy,
  output logic              overrun
);

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [LEN_W-1:0]   cnt;
  logic [LEN_W-1:0]   len_lat;

  logic               issue;
  logic               prod_valid;
  logic               in_flight;
  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   sum;
  logic [LEN_W-1:0]   frame_len;
  logic [LEN_W-1:0]   cnt_next;
  logic               done;
  logic               load;

  assign issue    = op_valid & op_ready;
  assign op_ready = ~(out_valid & ~out_ready);
  assign busy     = (state == ACCUM) | in_flight;

  valid_delay #(
    .LAT(LAT)
  ) u_valid_delay (
    .clk    (clk),
    .rst_n  (reset),
    .din    (issue),
    .dout   (prod_valid),
    .pending(in_flight)
  );

  always_comb begin
    prod_ext  = {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};
    frame_len = (len == '0) ? LEN_W'(1) : len;
    cnt_next  = cnt + LEN_W'(1);
    sum       = (state == IDLE) ? prod_ext : (acc + prod_ext);
    // A first product with an effective length of 1 closes its frame at once.
    done      = prod_valid & ((state == IDLE) ? (frame_len == LEN_W'(1))
                                              : (cnt_next == len_lat));
    load      = done & op_ready;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      len_lat   <= '0;
      out_valid <= 1'b0;
      acc_out   <= '0;
      overrun   <= 1'b0;
    end else begin
      if (prod_valid) begin
        acc <= sum;
        if (state == IDLE) begin
          cnt     <= LEN_W'(1);
          len_lat <= frame_len;
        end else begin
          cnt <= cnt_next;
        end
        state <= done ? IDLE : ACCUM;
      end

      if (load) begin
        acc_out   <= sum;
        out_valid <= 1'b1;
      end else if (out_valid & out_ready) begin
        out_valid <= 1'b0;
      end

      // Output register still held: the fresh sum is dropped and remembered.
      if (done & ~op_ready) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Frame-sum bench: table of frames through a modelled multiplier pipeline,
// scoreboarded output handshakes, plus overrun and mid-frame reset sequences.
module tb_mac_accumulator;
  import mac_accumulator_pkg::*;

  localparam int PW = DEF_PROD_W;
  localparam int AW = DEF_ACC_W;
  localparam int L  = DEF_LAT;
  localparam int LW = DEF_LEN_W;

  typedef struct {
    logic [LW-1:0]      len;
    int                 n;
    logic [3:0][PW-1:0] p;
    logic [AW-1:0]      exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic [LW-1:0] len;
  logic [PW-1:0] product;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [AW-1:0] acc_out;
  logic          busy;
  logic          overrun;

  logic [LW-1:0] op_len = '0;
  logic [PW-1:0] op_data = '0;
  logic [LW+PW-1:0] mpipe [L];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int first_issue = 0;
  int pop_cyc [$];
  logic [AW-1:0] sbq [$];
  logic [AW-1:0] mon_exp;
  vec_t vecs [7];

  mac_accumulator dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .len      (len),
    .product  (product),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .acc_out  (acc_out),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  // Multiplier model: operands and their frame length emerge L cycles after issue.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    mpipe[0] <= (op_valid && op_ready) ? {op_len, op_data} : '0;
    for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
  end
  assign {len, product} = mpipe[L-1];

  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: acc_out=%h but no frame sum was expected", acc_out);
      end else begin
        mon_exp = sbq.pop_front();
        pop_cyc.push_back(cyc);
        if (acc_out !== mon_exp) begin
          errors++;
          $display("FAIL frame_sum: acc_out=%h expected %h", acc_out, mon_exp);
        end else begin
          $display("cycle %0d frame sum %h accepted", cyc, acc_out);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      $display("check %s = %h", nm, act);
    end
  endtask

  task automatic send(input logic [LW-1:0] l, input logic [PW-1:0] d);
    op_valid = 1'b1;
    op_len   = l;
    op_data  = d;
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int k = 0;
    while (sbq.size() != 0 && k < maxc) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d sums still pending, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  function automatic vec_t mk(input logic [LW-1:0] l, input int n,
                              input logic [PW-1:0] a, input logic [PW-1:0] b,
                              input logic [PW-1:0] c, input logic [PW-1:0] d,
                              input logic [AW-1:0] e);
    vec_t r;
    r.len = l; r.n = n; r.p = {d, c, b, a}; r.exp = e;
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(8'd3, 3, 64'd5, -64'sd2, 64'd7, 64'd0, 72'd10);
    vecs[1] = mk(8'd0, 1, -64'sd1, 64'd0, 64'd0, 64'd0, {AW{1'b1}});
    vecs[2] = mk(8'd2, 2, 64'd3, 64'd4, 64'd0, 64'd0, 72'd7);
    vecs[3] = mk(8'd2, 2, 64'd10, -64'sd1, 64'd0, 64'd0, 72'd9);
    vecs[4] = mk(8'd4, 4, 64'd100, -64'sd200, 64'd300, -64'sd400, -72'sd200);
    vecs[5] = mk(8'd2, 2, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 64'd0,
                 72'h00_FFFF_FFFF_FFFF_FFFE);
    vecs[6] = mk(8'd1, 1, 64'd9, 64'd0, 64'd0, 64'd0, 72'd9);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", AW'(out_valid), '0);
    chk("reset_acc_out", acc_out, '0);
    chk("reset_overrun", AW'(overrun), '0);
    chk("reset_busy", AW'(busy), '0);
    chk("reset_op_ready", AW'(op_ready), AW'(1));
    reset = 1'b1;
    @(posedge clk); #1;

    // Back-to-back frames from the table, no idle cycles between them.
    for (int v = 0; v < 7; v++) begin
      sbq.push_back(vecs[v].exp);
      for (int i = 0; i < vecs[v].n; i++) begin
        if (v == 0 && i == 0) first_issue = cyc;
        send(vecs[v].len, vecs[v].p[i]);
      end
    end
    drain(50);
    if (pop_cyc.size() >= 4) begin
      chk("first_frame_latency", AW'(pop_cyc[0] - first_issue), AW'(L + 3));
      chk("back_to_back_gap", AW'(pop_cyc[3] - pop_cyc[2]), AW'(2));
    end else begin
      chk("pop_count", AW'(pop_cyc.size()), AW'(7));
    end
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", AW'(busy), '0);
    chk("idle_out_valid", AW'(out_valid), '0);

    // Longest frame of most-negative products must not wrap.
    sbq.push_back(72'h80_8000_0000_0000_0000);
    for (int i = 0; i < 255; i++) send(8'd255, 64'h8000_0000_0000_0000);
    chk("long_frame_busy", AW'(busy), AW'(1));
    drain(20);
    repeat (2) @(posedge clk);
    #1;

    // Two single-product frames complete while the output is blocked.
    out_ready = 1'b0;
    sbq.push_back(72'd11);
    send(8'd1, 64'd11);
    send(8'd1, 64'd12);
    repeat (6) @(posedge clk);
    #1;
    chk("blocked_out_valid", AW'(out_valid), AW'(1));
    chk("blocked_acc_out", acc_out, 72'd11);
    chk("blocked_overrun", AW'(overrun), AW'(1));
    chk("blocked_op_ready", AW'(op_ready), '0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("released_out_valid", AW'(out_valid), '0);
    chk("released_op_ready", AW'(op_ready), AW'(1));
    chk("overrun_sticky", AW'(overrun), AW'(1));
    drain(5);

    // Reset in the middle of a four-product frame.
    send(8'd4, 64'd1);
    send(8'd4, 64'd2);
    send(8'd4, 64'd3);
    op_valid = 1'b1; op_len = 8'd4; op_data = 64'd4;
    reset = 1'b0;
    @(posedge clk); #1;
    op_valid = 1'b0;
    chk("midreset_busy", AW'(busy), '0);
    chk("midreset_acc_out", acc_out, '0);
    reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("postreset_out_valid", AW'(out_valid), '0);
    chk("postreset_busy", AW'(busy), '0);
    chk("postreset_overrun", AW'(overrun), '0);
    sbq.push_back(72'd9);
    send(8'd1, 64'd9);
    drain(20);
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
